data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder (slave) end of the CPU load/store memory interface: serves one word-wide read or write request at a time.
- Uses a valid/ready request channel and a valid/ready response channel, with programmable wait-state latency, byte strobes and error signalling.
- Sits between the core's load/store path and the data RAM; replaces the zero-latency combinational data memory once the core issues handshaked requests.

Parameters:
- DEPTH, 256, number of 32-bit words in the storage array; power of two, 4..65536.
- LATENCY, 2, wait cycles between request acceptance and memory commit; 0..15.
- ADDR_BASE, 32'h0000_0000, byte address mapped to word 0; must be DEPTH*4 aligned.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables for stores; bit i covers byte i (bits 8i+7:8i); ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_err  out  1  request faulted (misaligned or out of range).

Behaviour:
- Reset behaviour:
  - rst_n low at a clock edge puts the FSM in IDLE and clears the wait counter and captured request.
  - Next cycle outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Storage array contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP. Exactly one request outstanding at a time.
- IDLE:
  - req_ready=1, resp_valid=0.
  - On req_valid&&req_ready at an edge: capture write, addr, wdata and wstrb; load the counter with LATENCY; go to WAIT.
  - Request inputs are don't-care after acceptance.
- WAIT:
  - req_ready=0, resp_valid=0.
  - If counter≠0: decrement.
  - If counter==0: commit the access at that edge, register resp_rdata and resp_err, go to RESP.
  - WAIT therefore lasts LATENCY+1 cycles. resp_valid is first high LATENCY+2 cycles after the accept cycle (2 cycles when LATENCY=0).
- Commit rules:
  - Word index = (addr−ADDR_BASE)>>2, computed as a 32-bit unsigned difference.
  - Error if addr[1:0]≠0 or index≥DEPTH (addresses below ADDR_BASE wrap to a large index and therefore fault).
  - Error: no array write, resp_rdata=0, resp_err=1.
  - Store: bytes with wstrb bit set are updated, others keep their value; resp_rdata=0, resp_err=0. wstrb=4'b0000 is a legal no-op store.
  - Load: resp_rdata = full stored word, resp_err=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until the handshake.
  - On resp_valid&&resp_ready: go to IDLE.
  - req_ready returns to 1 the cycle after the handshake. There is no same-cycle response-and-accept; maximum throughput is one request per LATENCY+3 cycles.
- Back-to-back same address: a load following a store to the same word returns the post-store value (the store has committed before its response is issued).
- Reset mid-operation: an uncommitted request (still in WAIT) is dropped with no array write. A committed store persists. A pending response is discarded.
- No combinational path from any input to req_ready or resp_valid; both are decoded from the state register only.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Store/load, LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, resp_ready=1 -> resp_valid high exactly 4 cycles after accept, err=0, rdata=0. Load 0x10 -> rdata=0xDEADBEEF.
- Byte strobes: word 0x20 holds 0x11223344; store wdata 0xAABBCCDD, wstrb 4'b0101 -> load 0x20 returns 0x11BB33DD.
- Errors:
  - Load 0x13 -> resp_err=1, rdata=0.
  - Store to ADDR_BASE+DEPTH*4 -> resp_err=1, array unchanged (load of word DEPTH−1 returns its prior value).
- Backpressure, LATENCY=0: hold resp_ready=0 for 5 cycles -> resp_valid stays 1 with rdata stable and req_ready=0 throughout. Handshake -> req_ready=1 the next cycle. Second request accepted only then.
- Reset mid-operation, LATENCY=5: accept store 0x40 = 0xCAFEF00D, assert rst_n in cycle 3 of WAIT -> after reset, load 0x40 returns its pre-store value; no stale resp_valid.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-wide load/store responder: one outstanding request, byte strobes, range/alignment faults.
// Latency: response valid LATENCY+2 cycles after the accept cycle; one request per LATENCY+3 cycles.
// Backpressure: resp_valid holds with stable data until resp_ready; req_ready only in IDLE.
module data_mem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH];

   logic [31:0] offset;
   logic [31:0] word_idx;
   logic        acc_err;
   logic [AW-1:0] mem_idx;
   logic [31:0] mem_rdat;
   logic [31:0] mem_wdat;
   logic        mem_we;

   // Decode the captured address and build the strobe-merged store word.
   always_comb begin
      offset   = addr_q - ADDR_BASE;
      word_idx = offset >> 2;
      // Addresses below ADDR_BASE wrap to a huge index and fault here too.
      acc_err  = (addr_q[1:0] != 2'b00) || (word_idx >= 32'(DEPTH));
      mem_idx  = word_idx[AW-1:0];
      mem_rdat = mem[mem_idx];
      mem_wdat = mem_rdat;
      for (int i = 0; i < 4; i++) begin
         if (wstrb_q[i]) begin
            mem_wdat[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   // Next-state, request capture and commit logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               cnt_d   = 4'(LATENCY);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_RESP;
               if (acc_err) begin
                  rdata_d = 32'h0;
                  err_d   = 1'b1;
               end else begin
                  err_d = 1'b0;
                  if (write_q) begin
                     mem_we  = 1'b1;
                     rdata_d = 32'h0;
                  end else begin
                     rdata_d = mem_rdat;
                  end
               end
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and captured-request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage write; contents survive reset, but a commit coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[mem_idx] <= mem_wdat;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
